// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: valid/ready key-code handshake into the keypad emulator queue
interface keypad_emulator_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    modport master (output key_valid, key_code, input key_ready);
    modport slave  (input key_valid, key_code, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad model that presses queued key codes against a column scan
module keypad_emulator #(
    parameter int HOLD_CYCLES = 200000,
    parameter int GAP_CYCLES  = 200000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_emulator_if.slave  key,
    input  logic [3:0]        KEY_C,
    output logic [3:0]        KEY_R,
    output logic              pressed,
    output logic              busy,
    output logic [7:0]        press_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL    = FIFO_DEPTH[AW:0];
    localparam logic [23:0] HOLD_LD = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] GAP_LD  = 24'(GAP_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
    state_t        state;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [23:0]   cnt;
    logic [3:0]    cur_code;
    logic          push, pop;
    assign key.key_ready = occ != FULL;
    assign push = key.key_valid && key.key_ready;
    assign pop  = state == IDLE && occ != '0;
    assign busy = state != IDLE || occ != '0;
    // row path is purely combinational so the scanner sees it one edge after driving a column
    assign KEY_R = (pressed && !KEY_C[cur_code[1:0]]) ? ~(4'b0001 << cur_code[3:2]) : 4'b1111;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= key.key_code;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            cnt         <= '0;
            cur_code    <= '0;
            pressed     <= 1'b0;
            press_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            case (state)
                IDLE: if (pop) begin
                    cur_code    <= mem[rd_ptr];
                    cnt         <= HOLD_LD;
                    press_count <= press_count + 1'b1;
                    pressed     <= 1'b1;
                    state       <= PRESS;
                end
                PRESS: if (cnt == '0) begin
                    cnt     <= GAP_LD;
                    pressed <= 1'b0;
                    state   <= RELEASE;
                end else cnt <= cnt - 1'b1;
                RELEASE: if (cnt == '0) state <= IDLE;
                         else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
